// File: rtl/uart_pkg.sv
// Shared constants for the framed UART transmitter: parity modes, FSM state
// encoding and the per-attempt bit-time count.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;
  localparam logic [2:0] ST_ACK    = 3'd5;

  typedef logic [2:0] state_t;

  // Bit times per transmission attempt, including the trailing ACK window.
  function automatic int frame_bits(input int data_w, input int par_mode, input int stop_bits);
    return 1 + data_w + ((par_mode != PARITY_NONE) ? 1 : 0) + stop_bits + 1;
  endfunction

endpackage

// File: rtl/uart_frame_xmit_if.sv
// Packet-source / line-side signal bundle of the framed UART transmitter.
interface uart_frame_xmit_if #(
  parameter int DATA_W     = 128,
  parameter int FIFO_DEPTH = 4
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [DATA_W-1:0] inval;
  logic              tx_wr;
  logic              rx_done;
  logic              tx_full;
  logic [CNT_W-1:0]  fifo_count;
  logic              busy;
  logic              UART_TX;
  logic              tx_ok;
  logic              tx_err;
  logic              overflow;

  modport master (
    output inval, tx_wr, rx_done,
    input  tx_full, fifo_count, busy, UART_TX, tx_ok, tx_err, overflow
  );

  modport slave (
    input  inval, tx_wr, rx_done,
    output tx_full, fifo_count, busy, UART_TX, tx_ok, tx_err, overflow
  );
endinterface

// File: rtl/xmit_fifo.sv
// Word queue for the transmitter; the head word stays readable until popped
// so a frame can be resent from it.
module xmit_fifo #(
  parameter int  DATA_W     = 128,
  parameter int  FIFO_DEPTH = 4,
  localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              rd_i,
  output logic [DATA_W-1:0] head_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [CNT_W-1:0]  count_o
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic              wr_en, rd_en;

  assign full_o  = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // Full is judged before any same-cycle pop, so a write at full is lost.
  assign wr_en = wr_i && !full_o;
  assign rd_en = rd_i && !empty_o;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_frame_xmit.sv
// Framed UART transmitter: queues words, sends each as start/data/parity/stop,
// then waits one bit time for a receiver ack and resends on a miss.
module uart_frame_xmit
  import uart_pkg::*;
#(
  parameter int DATA_W      = 128,
  parameter int OVERSAMPLE  = 16,
  parameter int FIFO_DEPTH  = 4,
  parameter int PARITY_MODE = PARITY_ODD,
  parameter int STOP_BITS   = 1,
  parameter int MAX_RETRY   = 3
) (
  input logic              clock,
  input logic              reset,
  uart_frame_xmit_if.slave bus
);
  localparam int CYC_W   = $clog2(OVERSAMPLE);
  localparam int BIT_W   = $clog2(DATA_W + 1);
  localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;

  state_t             state_q, state_d;
  logic [CYC_W-1:0]   cyc_q, cyc_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [DATA_W-1:0]  shift_q, shift_d;
  logic               par_q, par_d;
  logic               ack_q, ack_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic               tx_q, line_d;
  logic               ok_q, ok_d, err_q, err_d, ovf_q;

  logic [DATA_W-1:0]  head;
  logic               fifo_full, fifo_empty, pop, bit_end;
  logic [CNT_W-1:0]   fifo_count;

  xmit_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clock),
    .rst_n   (reset),
    .wr_i    (bus.tx_wr),
    .wdata_i (bus.inval),
    .rd_i    (pop),
    .head_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  function automatic logic word_parity(input logic [DATA_W-1:0] w);
    return (PARITY_MODE == PARITY_ODD) ? ~(^w) : (^w);
  endfunction

  assign bit_end = (cyc_q == CYC_W'(OVERSAMPLE - 1));

  always_comb begin
    state_d = state_q;
    cyc_d   = bit_end ? '0 : cyc_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    ack_d   = ack_q;
    retry_d = retry_q;
    line_d  = 1'b1;
    pop     = 1'b0;
    ok_d    = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cyc_d = '0;
        if (!fifo_empty) begin
          shift_d = head;
          par_d   = word_parity(head);
          bit_d   = '0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        line_d = 1'b0;
        if (bit_end) begin
          bit_d   = '0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        line_d = shift_q[0];
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_q == BIT_W'(DATA_W - 1)) begin
            bit_d   = '0;
            state_d = (PARITY_MODE != PARITY_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        line_d = par_q;
        if (bit_end) begin
          bit_d   = '0;
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          if (bit_q == BIT_W'(STOP_BITS - 1)) begin
            bit_d   = '0;
            ack_d   = 1'b0;
            state_d = ST_ACK;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      ST_ACK: begin
        ack_d = ack_q | bus.rx_done;
        if (bit_end) begin
          ack_d = 1'b0;
          if (ack_q | bus.rx_done) begin
            pop     = 1'b1;
            ok_d    = 1'b1;
            retry_d = '0;
            state_d = ST_IDLE;
          end else if (retry_q < RETRY_W'(MAX_RETRY)) begin
            // Resend straight from the head word, skipping IDLE.
            retry_d = retry_q + 1'b1;
            shift_d = head;
            par_d   = word_parity(head);
            bit_d   = '0;
            state_d = ST_START;
          end else begin
            pop     = 1'b1;
            err_d   = 1'b1;
            retry_d = '0;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The line is registered, so it trails the FSM state by one clock.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cyc_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      ack_q   <= 1'b0;
      retry_q <= '0;
      tx_q    <= 1'b1;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      ack_q   <= ack_d;
      retry_q <= retry_d;
      tx_q    <= line_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
      ovf_q   <= bus.tx_wr & fifo_full;
    end
  end

  assign bus.tx_full    = fifo_full;
  assign bus.fifo_count = fifo_count;
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.UART_TX    = tx_q;
  assign bus.tx_ok      = ok_q;
  assign bus.tx_err     = err_q;
  assign bus.overflow   = ovf_q;

endmodule

// File: tb/tb_uart_frame_xmit.sv
// Bench for uart_frame_xmit: three configurations share one clock and reset;
// expected frames are queued on write and compared sample-by-sample on the line.
module tb_uart_frame_xmit;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  int checks = 0;
  int errors = 0;

  // 0: 8-bit odd parity 1 stop; 1: 8-bit even parity 2 stops; 2: defaults
  uart_frame_xmit_if #(.DATA_W(8),   .FIFO_DEPTH(4)) ifa ();
  uart_frame_xmit_if #(.DATA_W(8),   .FIFO_DEPTH(4)) ifb ();
  uart_frame_xmit_if #(.DATA_W(128), .FIFO_DEPTH(4)) ifc ();

  uart_frame_xmit #(.DATA_W(8), .OVERSAMPLE(4), .FIFO_DEPTH(4), .PARITY_MODE(1),
                    .STOP_BITS(1), .MAX_RETRY(3))
    ua (.clock(clk), .reset(rst_n), .bus(ifa.slave));
  uart_frame_xmit #(.DATA_W(8), .OVERSAMPLE(4), .FIFO_DEPTH(4), .PARITY_MODE(2),
                    .STOP_BITS(2), .MAX_RETRY(3))
    ub (.clock(clk), .reset(rst_n), .bus(ifb.slave));
  uart_frame_xmit uc (.clock(clk), .reset(rst_n), .bus(ifc.slave));

  logic [127:0] din [3];
  logic [2:0]   wr, ack;

  assign ifa.inval   = din[0][7:0];
  assign ifb.inval   = din[1][7:0];
  assign ifc.inval   = din[2];
  assign ifa.tx_wr   = wr[0];
  assign ifb.tx_wr   = wr[1];
  assign ifc.tx_wr   = wr[2];
  assign ifa.rx_done = ack[0];
  assign ifb.rx_done = ack[1];
  assign ifc.rx_done = ack[2];

  wire [2:0] line_w = {ifc.UART_TX,  ifb.UART_TX,  ifa.UART_TX};
  wire [2:0] ok_w   = {ifc.tx_ok,    ifb.tx_ok,    ifa.tx_ok};
  wire [2:0] err_w  = {ifc.tx_err,   ifb.tx_err,   ifa.tx_err};
  wire [2:0] ovf_w  = {ifc.overflow, ifb.overflow, ifa.overflow};
  wire [2:0] full_w = {ifc.tx_full,  ifb.tx_full,  ifa.tx_full};
  wire [2:0] busy_w = {ifc.busy,     ifb.busy,     ifa.busy};

  int ok_cnt [3];
  int err_cnt [3];
  int ovf_cnt [3];

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (ok_w[k])  ok_cnt[k]  <= ok_cnt[k] + 1;
      if (err_w[k]) err_cnt[k] <= err_cnt[k] + 1;
      if (ovf_w[k]) ovf_cnt[k] <= ovf_cnt[k] + 1;
    end
  end

  function automatic int cnt_of(input int s);
    case (s)
      0:       return int'(ifa.fifo_count);
      1:       return int'(ifb.fifo_count);
      default: return int'(ifc.fifo_count);
    endcase
  endfunction

  typedef struct {
    int           sel;
    logic [135:0] bits;
    int           nbits;
    int           os;
  } sb_t;
  sb_t sb [$];

  typedef struct {
    int         sel;
    logic [7:0] data;
    logic       par;
  } vec_t;
  vec_t tbl [9];

  task automatic check(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Expected line levels, one entry per bit time: start, data LSB first,
  // parity, stop bit(s), ACK window.
  function automatic sb_t mk(input int sel, input logic [127:0] data, input logic par);
    sb_t e;
    int  dw    = (sel == 2) ? 128 : 8;
    int  stops = (sel == 1) ? 2 : 1;
    e.sel  = sel;
    e.os   = (sel == 2) ? 16 : 4;
    e.bits = '1;
    e.bits[0] = 1'b0;
    for (int i = 0; i < dw; i++) e.bits[1 + i] = data[i];
    e.bits[1 + dw] = par;
    e.nbits = 1 + dw + 1 + stops + 1;
    return e;
  endfunction

  task automatic write_word(input int sel, input logic [127:0] data, input bit push, input logic par);
    @(negedge clk);
    din[sel] = data;
    wr[sel]  = 1'b1;
    @(posedge clk);
    #1;
    wr[sel]  = 1'b0;
    if (push) sb.push_back(mk(sel, data, par));
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic capture(input int sel, input int exp_gap, input string nm,
                         output bit ok_last, output bit err_last);
    sb_t  e;
    int   gap = 0;
    bit   found = 1'b0;
    int   bad = -1;
    logic bad_val = 1'b0;
    bit   early = 1'b0;
    int   last;
    ok_last  = 1'b0;
    err_last = 1'b0;
    while (!found && gap < 3000) begin
      @(negedge clk);
      if (line_w[sel] === 1'b0) found = 1'b1;
      else gap++;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL %s_start: no start bit within %0d cycles", nm, gap);
      return;
    end
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s_sb: frame seen with nothing expected", nm);
      return;
    end
    e    = sb.pop_front();
    last = e.nbits * e.os - 1;
    for (int i = 0; i <= last; i++) begin
      if (i > 0) @(negedge clk);
      if (bad < 0 && line_w[sel] !== e.bits[i / e.os]) begin
        bad     = i;
        bad_val = line_w[sel];
      end
      if (i < last && (ok_w[sel] || err_w[sel])) early = 1'b1;
    end
    ok_last  = ok_w[sel];
    err_last = err_w[sel];
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s_frame: sample %0d (bit %0d) line=%0b, expected %0b",
               nm, bad, bad / e.os, bad_val, e.bits[bad / e.os]);
    end
    check({nm, "_early_pulse"}, early, 0);
    if (exp_gap >= 0) check({nm, "_gap"}, gap, exp_gap);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit    okl, errl;
    int    s, oks, errs, ovfs;
    string nm;

    for (int k = 0; k < 3; k++) din[k] = '0;
    wr    = '0;
    ack   = '0;
    rst_n = 1'b0;

    tbl[0] = '{sel: 0, data: 8'hA5, par: 1'b1};
    tbl[1] = '{sel: 0, data: 8'h00, par: 1'b1};
    tbl[2] = '{sel: 0, data: 8'hFF, par: 1'b1};
    tbl[3] = '{sel: 0, data: 8'h01, par: 1'b0};
    tbl[4] = '{sel: 0, data: 8'h7F, par: 1'b0};
    tbl[5] = '{sel: 1, data: 8'h03, par: 1'b0};
    tbl[6] = '{sel: 1, data: 8'h07, par: 1'b1};
    tbl[7] = '{sel: 1, data: 8'hFF, par: 1'b0};
    tbl[8] = '{sel: 1, data: 8'h80, par: 1'b1};

    settle(3);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst_line%0d", k), line_w[k], 1);
      check($sformatf("rst_count%0d", k), cnt_of(k), 0);
      check($sformatf("rst_busy%0d", k), busy_w[k], 0);
      check($sformatf("rst_full%0d", k), full_w[k], 0);
    end
    check("rst_pulses", {ok_w, err_w, ovf_w}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    settle(2);

    // Single acknowledged frames, both parity/stop configurations.
    for (int i = 0; i < 9; i++) begin
      s      = tbl[i].sel;
      ack[s] = 1'b1;
      oks    = ok_cnt[s];
      nm     = $sformatf("vec%0d", i);
      write_word(s, {120'b0, tbl[i].data}, 1'b1, tbl[i].par);
      @(negedge clk);
      check({nm, "_count_q"}, cnt_of(s), 1);
      check({nm, "_busy_pre"}, busy_w[s], 0);
      capture(s, 1, nm, okl, errl);
      check({nm, "_ok_last"}, okl, 1);
      check({nm, "_err_last"}, errl, 0);
      settle(2);
      check({nm, "_ok_once"}, ok_cnt[s] - oks, 1);
      check({nm, "_count_end"}, cnt_of(s), 0);
      check({nm, "_busy_end"}, busy_w[s], 0);
      $display("vec%0d sel=%0d data=%02h par=%0b done", i, s, tbl[i].data, tbl[i].par);
    end

    // No ack: one original plus three back-to-back retries, then a drop.
    ack[0] = 1'b0;
    oks    = ok_cnt[0];
    errs   = err_cnt[0];
    write_word(0, 128'h5A, 1'b1, 1'b1);
    for (int r = 0; r < 3; r++) sb.push_back(mk(0, 128'h5A, 1'b1));
    @(negedge clk);
    for (int r = 0; r < 4; r++) begin
      nm = $sformatf("retry%0d", r);
      capture(0, (r == 0) ? 1 : 0, nm, okl, errl);
      check({nm, "_ok_last"}, okl, 0);
      check({nm, "_err_last"}, errl, (r == 3) ? 1 : 0);
    end
    settle(2);
    check("retry_err_once", err_cnt[0] - errs, 1);
    check("retry_no_ok", ok_cnt[0] - oks, 0);
    check("retry_count", cnt_of(0), 0);
    check("retry_busy", busy_w[0], 0);
    $display("retry sequence done");

    // Fill the FIFO while the first frame is on the line; fifth write overflows.
    ack[0] = 1'b1;
    oks    = ok_cnt[0];
    ovfs   = ovf_cnt[0];
    write_word(0, 128'h01, 1'b1, 1'b0);
    fork
      begin
        bit o1, e1;
        capture(0, -1, "fifo_w1", o1, e1);
        check("fifo_w1_ok", o1, 1);
        capture(0, 1, "fifo_w2", o1, e1);
        check("fifo_w2_ok", o1, 1);
        capture(0, 1, "fifo_w3", o1, e1);
        check("fifo_w3_ok", o1, 1);
        capture(0, 1, "fifo_w4", o1, e1);
        check("fifo_w4_ok", o1, 1);
      end
      begin
        write_word(0, 128'h02, 1'b1, 1'b0);
        write_word(0, 128'h03, 1'b1, 1'b1);
        check("fifo_full_at3", full_w[0], 0);
        write_word(0, 128'h04, 1'b1, 1'b0);
        check("fifo_full_at4", full_w[0], 1);
        check("fifo_count_at4", cnt_of(0), 4);
        write_word(0, 128'h05, 1'b0, 1'b0);
        settle(1);
        check("fifo_overflow", ovf_cnt[0] - ovfs, 1);
        check("fifo_count_after_ovf", cnt_of(0), 4);
      end
    join
    settle(2);
    check("fifo_ok_total", ok_cnt[0] - oks, 4);
    check("fifo_count_end", cnt_of(0), 0);
    check("fifo_ovf_total", ovf_cnt[0] - ovfs, 1);
    $display("fifo fill sequence done");

    // Asynchronous reset in the middle of the data bits.
    oks  = ok_cnt[0];
    errs = err_cnt[0];
    write_word(0, 128'h00, 1'b1, 1'b1);
    repeat (12) @(negedge clk);
    check("mid_line_low", line_w[0], 0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_line", line_w[0], 1);
    check("mid_rst_count", cnt_of(0), 0);
    check("mid_rst_busy", busy_w[0], 0);
    if (sb.size() > 0) void'(sb.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    settle(3);
    check("post_rst_no_ok", ok_cnt[0] - oks, 0);
    check("post_rst_no_err", err_cnt[0] - errs, 0);
    check("post_rst_line", line_w[0], 1);
    write_word(0, 128'hC3, 1'b1, 1'b1);
    @(negedge clk);
    capture(0, 1, "post_rst", okl, errl);
    check("post_rst_ok", okl, 1);
    settle(2);
    $display("mid-frame reset sequence done");

    // Default 128-bit configuration, both end bits set.
    ack[2] = 1'b1;
    oks    = ok_cnt[2];
    write_word(2, {1'b1, 126'b0, 1'b1}, 1'b1, 1'b1);
    @(negedge clk);
    capture(2, 1, "wide", okl, errl);
    check("wide_ok_last", okl, 1);
    settle(2);
    check("wide_ok_once", ok_cnt[2] - oks, 1);
    check("wide_count_end", cnt_of(2), 0);
    $display("wide frame done");

    check("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
